// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, state encoding and defaults for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_COUNT  = 32;
  localparam int ADDR_WIDTH = $clog2(REG_COUNT);
  localparam int MAX_WAIT   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB and one MDU result; flags MDU hazards to decode.
// Build option REGFILE_ARB_FAIRNESS_EN bounds how long a held MDU result can be starved by WB.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = regfile_write_arbiter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_write_arbiter_pkg::ADDR_WIDTH,
  parameter int MAX_WAIT   = regfile_write_arbiter_pkg::MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_ready_o,
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic                  mdu_valid_i,
  input  logic [DATA_WIDTH-1:0] mdu_data_i,
  output logic                  mdu_ready_o,
  input  logic [ADDR_WIDTH-1:0] rs1_i,
  input  logic [ADDR_WIDTH-1:0] rs2_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  output logic                  hazard_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o
);
  import regfile_write_arbiter_pkg::*;

  // state | meaning
  // IDLE  | no MDU op outstanding
  // BUSY  | op issued, result not yet returned
  // HOLD  | result captured, waiting for the write port

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("MAX_WAIT must be in 1..15");
  end

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pending_rd_q, pending_rd_d;
  logic [DATA_WIDTH-1:0] held_q, held_d;
  logic                  mdu_grant;
  logic                  force_grant;

`ifdef REGFILE_ARB_FAIRNESS_EN
  logic [3:0] wait_cnt_q;

  assign force_grant = (state_q == HOLD) && (wait_cnt_q == 4'(MAX_WAIT));

  // Counts HOLD cycles lost to WB; reaching MAX_WAIT forces the MDU in.
  always_ff @(posedge clk) begin
    if (!rst_n)                 wait_cnt_q <= '0;
    else if (mdu_grant)         wait_cnt_q <= '0;
    else if (state_q == HOLD)   wait_cnt_q <= wait_cnt_q + 4'd1;
  end
`else
  assign force_grant = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_rd_q <= '0;
      held_q       <= '0;
    end else begin
      state_q      <= state_d;
      pending_rd_q <= pending_rd_d;
      held_q       <= held_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_rd_d  = pending_rd_q;
    held_d        = held_q;
    mdu_grant     = (state_q == HOLD) && (!wb_valid_i || force_grant);
    wb_ready_o    = !force_grant;
    issue_ready_o = (state_q == IDLE) || mdu_grant;
    mdu_ready_o   = (state_q == BUSY);
    case (state_q)
      IDLE: begin
        if (issue_valid_i) begin
          state_d      = BUSY;
          pending_rd_d = issue_rd_i;
        end
      end
      BUSY: begin
        if (mdu_valid_i) begin
          state_d = HOLD;
          held_d  = mdu_data_i;
        end
      end
      HOLD: begin
        // Grant cycle can accept the next issue directly, with no idle bubble.
        if (mdu_grant) begin
          if (issue_valid_i) begin
            state_d      = BUSY;
            pending_rd_d = issue_rd_i;
          end else begin
            state_d      = IDLE;
            pending_rd_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hazard_o = (state_q != IDLE) && (pending_rd_q != '0) &&
                    ((pending_rd_q == rs1_i) || (pending_rd_q == rs2_i) || (pending_rd_q == rd_i));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_o      <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else if (mdu_grant) begin
      we_o      <= (pending_rd_q != '0);
      wr_addr_o <= pending_rd_q;
      wr_data_o <= held_q;
    end else begin
      we_o      <= wb_valid_i && (wb_addr_i != '0);
      wr_addr_o <= wb_addr_i;
      wr_data_o <= wb_data_i;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (WB) and one long-latency multiply/divide unit (MDU) result.
- Tracks the MDU's pending destination register and flags RAW/WAW hazards to decode.
- Sits between the WB stage, the MDU and the register file. Drives the register file's write enable, address and data.

Parameters:
- DATA_WIDTH, 32, write data width; defaults from the shared package.
- ADDR_WIDTH, 5, register address width.
- MAX_WAIT, 4, maximum cycles a held MDU result waits before WB is refused. Only used when the optional feature is compiled in. Legal range is 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- wb_valid_i  in  1  WB write request
- wb_addr_i  in  ADDR_WIDTH  WB destination register
- wb_data_i  in  DATA_WIDTH  WB data
- wb_ready_o  out  1  WB granted this cycle. When low, the pipeline holds WB and stalls.
- issue_valid_i  in  1  MDU op issued this cycle
- issue_rd_i  in  ADDR_WIDTH  MDU destination register
- issue_ready_o  out  1  arbiter can accept an MDU issue
- mdu_valid_i  in  1  MDU result valid
- mdu_data_i  in  DATA_WIDTH  MDU result
- mdu_ready_o  out  1  result accepted
- rs1_i, rs2_i, rd_i  in  ADDR_WIDTH each  decode-stage operand and destination addresses
- hazard_o  out  1  decode must stall
- we_o  out  1  register file write enable
- wr_addr_o  out  ADDR_WIDTH  register file write address
- wr_data_o  out  DATA_WIDTH  register file write data

Behaviour:
- Reset values:
  - we_o=0, wr_addr_o=0, wr_data_o=0.
  - FSM=IDLE, pending_rd=0, held data=0, wait_cnt=0.
  - Combinational outputs follow from reset state: wb_ready_o=1, issue_ready_o=1, mdu_ready_o=0, hazard_o=0.
- FSM states:
  - IDLE: no MDU op outstanding.
  - BUSY: issued, result not yet returned.
  - HOLD: result captured, waiting for the write port.
- Transitions:
  - IDLE->BUSY on issue_valid_i && issue_ready_o. Captures issue_rd_i into pending_rd.
  - BUSY->HOLD on mdu_valid_i. mdu_ready_o=1 in BUSY only; the result is captured regardless of WB.
  - HOLD->IDLE when the MDU is granted the port.
  - HOLD->BUSY when the MDU is granted the port and issue_valid_i is high in the same cycle.
- issue_ready_o is high in IDLE, or in HOLD during the MDU grant cycle. An issue while issue_ready_o is low is ignored.
- issue_rd_i=0: the op is accepted and sequenced normally, but no write is generated (we_o stays 0) and it never raises hazard_o.
- Grant rule, evaluated combinationally each cycle:
  - MDU is granted in HOLD when !wb_valid_i, or when the forced-grant condition holds.
  - Otherwise WB is granted. wb_ready_o = !(forced grant).
- Output write:
  - The write is registered: a grant in cycle N drives we_o/wr_addr_o/wr_data_o in cycle N+1, for exactly one cycle.
  - A WB grant with wb_addr_i=0 or wb_valid_i=0 gives we_o=0 in N+1.
- Hazard:
  - hazard_o = (state!=IDLE) && pending_rd!=0 && (pending_rd==rs1_i || pending_rd==rs2_i || pending_rd==rd_i).
  - The pending flag clears on the MDU grant edge, so hazard_o drops in the same cycle we_o carries the MDU write. The register file's write-through bypass supplies the value.
- Same-address conflict: WB and MDU targeting the same rd cannot be in flight together because decode stalls on rd_i. No extra ordering logic is required.
- Reset mid-operation: a synchronous reset discards BUSY/HOLD state and any held result. No write is issued.

Optional Feature:
- Macro REGFILE_ARB_FAIRNESS_EN.
- Defined:
  - wait_cnt increments each HOLD cycle in which WB is granted.
  - When wait_cnt==MAX_WAIT, the MDU is force-granted and wb_ready_o=0 for that cycle.
  - wait_cnt clears on MDU grant.
  - A held result therefore waits at most MAX_WAIT cycles.
- Undefined: there is no counter and wb_ready_o is constantly 1. The MDU writes only in WB-idle cycles and may starve.

Decomposition:
- Shared package holds: DATA_WIDTH, ADDR_WIDTH, REG_COUNT; an arb_state_e typedef (IDLE/BUSY/HOLD); and the MAX_WAIT default.
- A single module; no sub-module is warranted. The hazard comparator stays inline.

Test Plan:
- Reset, then issue rd=5. Result 0xDEADBEEF arrives 3 cycles later with WB idle -> we_o=1, wr_addr_o=5, wr_data_o=0xDEADBEEF one cycle after the grant. hazard_o is high throughout for rs1_i=5 and drops in the we_o cycle.
- Result held while wb_valid_i is continuously high, feature enabled, MAX_WAIT=4 -> four WB writes, then wb_ready_o=0 for one cycle and the MDU write appears. Feature disabled -> the MDU never writes until wb_valid_i drops.
- HOLD grant cycle with issue_valid_i=1 and rd=7 -> the old result is written, the FSM goes to BUSY, and pending_rd=7 with no idle cycle.
- issue_rd_i=0 -> full sequence runs, we_o stays 0, and hazard_o stays 0 for rs1_i=0.
- WB write to addr 0, data 0x1234 -> we_o=0.
- rst_n low while in HOLD -> next cycle FSM=IDLE, hazard_o=0, and no write is ever produced.
